icache_ctrl: RTL and testbench
==============================

// Module: icache_ctrl
// PURPOSE
// Sequencing controller for the 8-set x 8-way I-cache. Sits between the IFU fetch port and the
// AXI-style memory read port. Owns the valid/tag arrays and the line data storage. Drives the
// replacement unit: rp_access on every hit/fill, rp_invalid on every flushed entry; rp_victim
// selects the way on a miss. Also walks all entries for fence.i flush.
// PARAMETERS
// NSET       8   sets; index width IDX_W = $clog2(NSET) = 3
// NWAY       8   ways; way width WAY_W = $clog2(NWAY) = 3
// LINE_WORDS 4   32-bit words per line; offset = 4 bits (16 B line)
// ADDR_W     32  address width; TAG_W = ADDR_W - IDX_W - 4 = 25
// PORTS
// clk         in   1       clock
// rst         in   1       reset
// req_valid   in   1       fetch request valid
// req_ready   out  1       controller accepts request (IDLE, no flush pending)
// req_addr    in   ADDR_W  fetch address, word aligned
// rsp_valid   out  1       fetch data valid
// rsp_ready   in   1       IFU accepts response
// rsp_data    out  32      fetched word
// rsp_err     out  1       refill returned rresp!=0 (valid with rsp_valid)
// flush       in   1       fence.i flush request (pulse or level)
// flush_done  out  1       1-cycle pulse when walk completes
// mem_arvalid out  1       refill address valid
// mem_arready in   1       memory accepts address
// mem_araddr  out  ADDR_W  line-aligned refill address ({tag,idx,4'b0})
// mem_arlen   out  8       constant LINE_WORDS-1
// mem_rvalid  in   1       refill beat valid
// mem_rready  out  1       controller accepts beat (1 in REFILL)
// mem_rdata   in   32      refill beat data
// mem_rlast   in   1       last beat marker
// mem_rresp   in   2       beat response; nonzero = error
// rp_idx      out  IDX_W   replacer set index
// rp_way      out  WAY_W   replacer way for access/invalid
// rp_access   out  1       1-cycle pulse: way used
// rp_invalid  out  1       1-cycle pulse: way freed
// rp_victim   in   WAY_W   replacer's chosen victim for rp_idx (combinational)
// BEHAVIOUR
// - Reset: rst is synchronous, active-high. All valid bits cleared, state IDLE, flush_pend=0.
//   All outputs are 0 during the reset cycle, including req_ready.
// - FSM states: IDLE, LOOKUP, MISS_AR, REFILL, RESP, FLUSH.
// - IDLE: req_ready=!flush_pend&&!flush.
//   - flush or flush_pend -> FLUSH. Flush beats req when both are asserted in the same cycle.
//   - Otherwise req_valid -> latch addr, go to LOOKUP.
// - LOOKUP (1 cycle): compare the tag across all valid ways of idx; rp_idx=idx.
//   - Hit: rsp_data=word, rp_access pulse with rp_way=hit way, go to RESP. Hit latency is
//     2 cycles from acceptance to rsp_valid.
//   - Miss: latch victim=rp_victim, go to MISS_AR.
// - MISS_AR: mem_arvalid=1 until mem_arready, then go to REFILL with beat counter=0.
// - REFILL: mem_rready=1; each rvalid writes data[idx][victim][beat], beat++. rresp!=0 sets
//   err_sticky.
//   - Line completes on the beat where mem_rlast=1 or beat==LINE_WORDS-1, whichever is first.
//   - On completion, if !err_sticky: valid=1, tag written, rp_access pulse with way=victim.
//     If err_sticky: line stays invalid, no rp_access.
//   - rsp_data = requested word (captured as it streams), rsp_err=err_sticky. Go to RESP.
// - RESP: rsp_valid=1, rsp_data/rsp_err held stable until rsp_ready. Then go to IDLE.
// - FLUSH: a counter walks {set,way} from 0 to NSET*NWAY-1, one entry per cycle.
//   - Each cycle: clear valid, rp_invalid pulse with rp_idx/rp_way=counter.
//   - After the last entry: flush_done pulse, flush_pend=0, go to IDLE. Walk = 64 cycles.
// - flush asserted in any non-IDLE state sets flush_pend. It is serviced on the next IDLE.
//   An in-flight miss always completes first.
// - rp_access and rp_invalid are never asserted in the same cycle.
// - rst mid-refill: return to IDLE, abandon the burst, all lines invalid. Memory-side
//   cleanup is owned by the system reset.
// STRUCTURE
// - Shared package icache_pkg: NSET/NWAY/LINE_WORDS, IDX_W/WAY_W/TAG_W, and the state enum
//   icache_state_e.
// - One sub-module, icache_tag_array: valid+tag storage, one write port, NWAY-wide parallel
//   compare returning hit/hit_way. Data storage and FSM stay in icache_ctrl.
// TESTING
// - Cold miss 0x8000_0004: AR 0x8000_0000, arlen=3, 4 beats A0..A3 -> rsp_data=A1,
//   rp_access way=victim.
// - Hit 0x8000_0008 after that fill -> rsp_valid 2 cycles after handshake, data=A2, no AR,
//   rp_access with way=that way.
// - Nine distinct tags on set 0, replacer forcing victim=5 -> 9th fill lands in way 5 and
//   the old way-5 address misses again.
// - Flush during REFILL -> refill completes, RESP delivered, then 64 rp_invalid pulses
//   (idx 0..7 x way 0..7), flush_done once; next fetch misses.
// - mem_rresp=2 on beat 2 -> rsp_err=1 and the line is not validated (refetch misses).
// - rsp_ready held low 5 cycles in RESP -> rsp_valid and rsp_data stable; req_ready=0
//   throughout.

Source files
------------

// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : icache_pkg
//  Description : Shared geometry constants and FSM state type for the I-cache
//                controller and its tag array.
//  Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

    localparam int NSET       = 8;
    localparam int NWAY       = 8;
    localparam int LINE_WORDS = 4;
    localparam int ADDR_W     = 32;

    localparam int IDX_W   = $clog2(NSET);
    localparam int WAY_W   = $clog2(NWAY);
    localparam int WORD_W  = $clog2(LINE_WORDS);
    localparam int OFF_W   = WORD_W + 2;
    localparam int TAG_W   = ADDR_W - IDX_W - OFF_W;
    localparam int ENTRY_W = IDX_W + WAY_W;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOOKUP  = 3'd1,
        ST_MISS_AR = 3'd2,
        ST_REFILL  = 3'd3,
        ST_RESP    = 3'd4,
        ST_FLUSH   = 3'd5
    } icache_state_e;

endpackage
`default_nettype wire

// File: rtl/icache_tag_array.sv
`default_nettype none
// ============================================================================
//  Module      : icache_tag_array
//  Description : Valid + tag storage with a single write port and a parallel
//                NWAY-wide tag compare for one set.
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_tag_array
    import icache_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_lk_idx,
    input  logic [TAG_W-1:0] i_lk_tag,
    output logic             o_hit,
    output logic [WAY_W-1:0] o_hit_way,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [WAY_W-1:0] i_wr_way,
    input  logic             i_wr_valid,
    input  logic [TAG_W-1:0] i_wr_tag
);

    logic [NWAY-1:0]  r_valid [NSET];
    logic [TAG_W-1:0] r_tag   [NSET][NWAY];
    logic [NWAY-1:0]  w_match;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NSET; s++) begin
                r_valid[s] <= '0;
            end
        end else if (i_wr_en) begin
            r_valid[i_wr_idx][i_wr_way] <= i_wr_valid;
        end
    end

    // Tags only need writing when an entry becomes valid.
    always_ff @(posedge clk) begin
        if (i_wr_en && i_wr_valid) begin
            r_tag[i_wr_idx][i_wr_way] <= i_wr_tag;
        end
    end

    generate
        for (genvar w = 0; w < NWAY; w++) begin : g_cmp
            assign w_match[w] = r_valid[i_lk_idx][w] && (r_tag[i_lk_idx][w] == i_lk_tag);
        end
    endgenerate

    always_comb begin
        o_hit_way = '0;
        for (int w = NWAY - 1; w >= 0; w--) begin
            if (w_match[w]) begin
                o_hit_way = WAY_W'(w);
            end
        end
    end

    assign o_hit = |w_match;

endmodule
`default_nettype wire

// File: rtl/icache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : icache_ctrl
//  Description : 8-set x 8-way I-cache sequencer: lookup, line refill over an
//                AXI-style read port, replacer handshakes and fence.i walk.
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_ctrl
    import icache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    input  logic              flush,
    output logic              flush_done,
    output logic              mem_arvalid,
    input  logic              mem_arready,
    output logic [ADDR_W-1:0] mem_araddr,
    output logic [7:0]        mem_arlen,
    input  logic              mem_rvalid,
    output logic              mem_rready,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rlast,
    input  logic [1:0]        mem_rresp,
    output logic [IDX_W-1:0]  rp_idx,
    output logic [WAY_W-1:0]  rp_way,
    output logic              rp_access,
    output logic              rp_invalid,
    input  logic [WAY_W-1:0]  rp_victim
);

    localparam logic [WORD_W-1:0] c_last_beat = WORD_W'(LINE_WORDS - 1);
    localparam logic [7:0]        c_arlen     = 8'(LINE_WORDS - 1);

    icache_state_e r_state, w_state_nxt;

    logic [ADDR_W-1:0]  r_addr;
    logic [WAY_W-1:0]   r_victim;
    logic [WORD_W-1:0]  r_beat;
    logic               r_err;
    logic               r_flush_pend;
    logic [31:0]        r_rsp_data;
    logic [ENTRY_W-1:0] r_flush_cnt;
    logic [31:0]        r_data [NSET*NWAY*LINE_WORDS];

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [WORD_W-1:0] w_word;
    logic              w_unused_addr_lsb;
    logic              w_hit;
    logic [WAY_W-1:0]  w_hit_way;
    logic              w_beat_err, w_line_done, w_fill_err;

    logic              w_req_ready, w_rsp_valid, w_arvalid, w_rready;
    logic [IDX_W-1:0]  w_rp_idx;
    logic [WAY_W-1:0]  w_rp_way;
    logic              w_rp_access, w_rp_invalid, w_flush_done;
    logic              w_tag_wr_en, w_tag_wr_valid;
    logic [IDX_W-1:0]  w_tag_wr_idx;
    logic [WAY_W-1:0]  w_tag_wr_way;

    assign w_idx             = r_addr[OFF_W +: IDX_W];
    assign w_tag             = r_addr[ADDR_W-1 -: TAG_W];
    assign w_word            = r_addr[2 +: WORD_W];
    assign w_unused_addr_lsb = ^r_addr[1:0];

    assign w_beat_err  = (mem_rresp != 2'b00);
    assign w_line_done = mem_rvalid && (mem_rlast || (r_beat == c_last_beat));
    assign w_fill_err  = r_err || w_beat_err;

    icache_tag_array u_tag_array (
        .clk        (clk),
        .rst        (rst),
        .i_lk_idx   (w_idx),
        .i_lk_tag   (w_tag),
        .o_hit      (w_hit),
        .o_hit_way  (w_hit_way),
        .i_wr_en    (w_tag_wr_en),
        .i_wr_idx   (w_tag_wr_idx),
        .i_wr_way   (w_tag_wr_way),
        .i_wr_valid (w_tag_wr_valid),
        .i_wr_tag   (w_tag)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_req_ready    = 1'b0;
        w_rsp_valid    = 1'b0;
        w_arvalid      = 1'b0;
        w_rready       = 1'b0;
        w_rp_idx       = w_idx;
        w_rp_way       = r_victim;
        w_rp_access    = 1'b0;
        w_rp_invalid   = 1'b0;
        w_flush_done   = 1'b0;
        w_tag_wr_en    = 1'b0;
        w_tag_wr_idx   = w_idx;
        w_tag_wr_way   = r_victim;
        w_tag_wr_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = !r_flush_pend && !flush;
                if (flush || r_flush_pend) begin
                    w_state_nxt = ST_FLUSH;
                end else if (req_valid) begin
                    w_state_nxt = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (w_hit) begin
                    w_rp_access = 1'b1;
                    w_rp_way    = w_hit_way;
                    w_state_nxt = ST_RESP;
                end else begin
                    // Drop the victim now so a failed refill never leaves stale data valid.
                    w_tag_wr_en  = 1'b1;
                    w_tag_wr_way = rp_victim;
                    w_state_nxt  = ST_MISS_AR;
                end
            end
            ST_MISS_AR: begin
                w_arvalid = 1'b1;
                if (mem_arready) begin
                    w_state_nxt = ST_REFILL;
                end
            end
            ST_REFILL: begin
                w_rready = 1'b1;
                if (w_line_done) begin
                    w_tag_wr_en    = 1'b1;
                    w_tag_wr_valid = !w_fill_err;
                    w_rp_access    = !w_fill_err;
                    w_state_nxt    = ST_RESP;
                end
            end
            ST_RESP: begin
                w_rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                w_rp_invalid = 1'b1;
                w_rp_idx     = r_flush_cnt[ENTRY_W-1:WAY_W];
                w_rp_way     = r_flush_cnt[WAY_W-1:0];
                w_tag_wr_en  = 1'b1;
                w_tag_wr_idx = r_flush_cnt[ENTRY_W-1:WAY_W];
                w_tag_wr_way = r_flush_cnt[WAY_W-1:0];
                if (r_flush_cnt == '1) begin
                    w_flush_done = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= '0;
            r_victim     <= '0;
            r_beat       <= '0;
            r_err        <= 1'b0;
            r_flush_pend <= 1'b0;
            r_rsp_data   <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (flush && (r_state != ST_IDLE)) begin
                r_flush_pend <= 1'b1;
            end else if (w_flush_done) begin
                r_flush_pend <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    r_flush_cnt <= '0;
                    if (req_valid && w_req_ready) begin
                        r_addr <= req_addr;
                    end
                end
                ST_LOOKUP: begin
                    r_err <= 1'b0;
                    if (w_hit) begin
                        r_rsp_data <= r_data[{w_idx, w_hit_way, w_word}];
                    end else begin
                        r_victim <= rp_victim;
                        r_beat   <= '0;
                    end
                end
                ST_REFILL: begin
                    if (mem_rvalid) begin
                        r_beat <= r_beat + 1'b1;
                        if (w_beat_err) begin
                            r_err <= 1'b1;
                        end
                        if (r_beat == w_word) begin
                            r_rsp_data <= mem_rdata;
                        end
                    end
                end
                ST_FLUSH: r_flush_cnt <= r_flush_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && (r_state == ST_REFILL) && mem_rvalid) begin
            r_data[{w_idx, r_victim, r_beat}] <= mem_rdata;
        end
    end

    // Every output is forced low while reset is asserted.
    assign req_ready   = !rst && w_req_ready;
    assign rsp_valid   = !rst && w_rsp_valid;
    assign rsp_data    = rst ? '0 : r_rsp_data;
    assign rsp_err     = !rst && r_err;
    assign flush_done  = !rst && w_flush_done;
    assign mem_arvalid = !rst && w_arvalid;
    assign mem_araddr  = (!rst && w_arvalid) ? {w_tag, w_idx, {OFF_W{1'b0}}} : '0;
    assign mem_arlen   = rst ? 8'd0 : c_arlen;
    assign mem_rready  = !rst && w_rready;
    assign rp_idx      = rst ? '0 : w_rp_idx;
    assign rp_way      = rst ? '0 : w_rp_way;
    assign rp_access   = !rst && w_rp_access;
    assign rp_invalid  = !rst && w_rp_invalid;

endmodule
`default_nettype wire

// File: tb/tb_icache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_ctrl
//  Description : Directed self-checking bench for icache_ctrl with an inline
//                memory responder and a bench-driven replacer victim.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        flush;
    logic        flush_done;
    logic        mem_arvalid;
    logic        mem_arready;
    logic [31:0] mem_araddr;
    logic [7:0]  mem_arlen;
    logic        mem_rvalid;
    logic        mem_rready;
    logic [31:0] mem_rdata;
    logic        mem_rlast;
    logic [1:0]  mem_rresp;
    logic [2:0]  rp_idx;
    logic [2:0]  rp_way;
    logic        rp_access;
    logic        rp_invalid;
    logic [2:0]  rp_victim;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;

    icache_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .flush       (flush),
        .flush_done  (flush_done),
        .mem_arvalid (mem_arvalid),
        .mem_arready (mem_arready),
        .mem_araddr  (mem_araddr),
        .mem_arlen   (mem_arlen),
        .mem_rvalid  (mem_rvalid),
        .mem_rready  (mem_rready),
        .mem_rdata   (mem_rdata),
        .mem_rlast   (mem_rlast),
        .mem_rresp   (mem_rresp),
        .rp_idx      (rp_idx),
        .rp_way      (rp_way),
        .rp_access   (rp_access),
        .rp_invalid  (rp_invalid),
        .rp_victim   (rp_victim)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory word for any address is the address XOR a fixed pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // One fetch from acceptance to response handshake. Entered and left just
    // after a falling edge. `way` is the expected hit way, or the victim offered on a miss.
    task automatic fetch(input logic [31:0] addr, input bit exp_hit, input logic [2:0] way,
                         input int err_beat, input bit flush_mid, input int hold);
        logic [31:0] exp_data;
        bit          exp_err;
        exp_data = mem_word(addr);
        exp_err  = !exp_hit && (err_beat >= 0);
        req_valid = 1'b1;
        req_addr  = addr;
        rp_victim = way;
        #1 chk("req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = '0;
        #1;
        chk("lookup", {rp_access, rp_idx, rsp_valid, mem_arvalid}, {exp_hit, addr[6:4], 1'b0, 1'b0});
        if (exp_hit) begin
            chk("hit_way", {29'd0, rp_way}, {29'd0, way});
            @(negedge clk);
        end else begin
            @(negedge clk);
            #1;
            chk("ar_valid_len", {mem_arvalid, mem_arlen}, {1'b1, 8'd3});
            chk("ar_addr", mem_araddr, {addr[31:4], 4'h0});
            mem_arready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            mem_arready = 1'b0;
            for (int b = 0; b < 4; b++) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word({addr[31:4], 2'(b), 2'b00});
                mem_rresp  = (b == err_beat) ? 2'd2 : 2'd0;
                mem_rlast  = (b == 3);
                flush      = flush_mid && (b == 1);
                #1;
                chk("fill_beat", {rp_access, rp_way, mem_rready, rsp_valid},
                    {(b == 3) && !exp_err, way, 1'b1, 1'b0});
                @(posedge clk);
                @(negedge clk);
            end
            mem_rvalid = 1'b0;
            mem_rlast  = 1'b0;
            mem_rresp  = 2'd0;
            flush      = 1'b0;
        end
        #1;
        chk("rsp_flags", {rsp_valid, rsp_err, mem_arvalid, rp_access}, {1'b1, exp_err, 1'b0, 1'b0});
        chk("rsp_data", rsp_data, exp_data);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            chk("hold_flags", {rsp_valid, req_ready, rsp_err}, {1'b1, 1'b0, exp_err});
            chk("hold_data", rsp_data, exp_data);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        #1 chk("rsp_done", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_addr    = '0;
        rsp_ready   = 1'b0;
        flush       = 1'b0;
        mem_arready = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        mem_rlast   = 1'b0;
        mem_rresp   = 2'd0;
        rp_victim   = '0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_outputs", {req_ready, rsp_valid, rsp_err, mem_arvalid, mem_rready,
                            rp_access, rp_invalid, flush_done}, 32'd0);
        chk("rst_arlen", {24'd0, mem_arlen}, 32'd0);
        rst = 1'b0;
        #1 chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // Cold miss, hit two cycles after acceptance, then a stalled response.
        fetch(32'h8000_0004, 1'b0, 3'd3, -1, 1'b0, 0);
        fetch(32'h8000_0008, 1'b1, 3'd3, -1, 1'b0, 0);
        fetch(32'h8000_000C, 1'b1, 3'd3, -1, 1'b0, 5);

        // Error on beat 2: line must stay invalid; good refill then hits.
        fetch(32'h4000_0010, 1'b0, 3'd2, 2, 1'b0, 0);
        fetch(32'h4000_0010, 1'b0, 3'd2, -1, 1'b0, 0);
        fetch(32'h4000_0014, 1'b1, 3'd2, -1, 1'b0, 0);

        // Flush raised during refill: fill and response finish first, then the walk.
        fetch(32'h2000_0020, 1'b0, 3'd1, -1, 1'b1, 0);
        chk("pend_idle", {req_ready, rp_invalid, flush_done}, 32'd0);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            #1;
            chk("flush_walk", {rp_access, rp_invalid, rp_idx, rp_way, flush_done, req_ready},
                {1'b0, 1'b1, 6'(i), (i == 63), 1'b0});
            if (flush_done) done_cnt++;
        end
        @(negedge clk);
        #1;
        chk("flush_end", {rp_invalid, flush_done, req_ready}, 32'b001);
        chk("flush_done_cnt", done_cnt, 32'd1);
        fetch(32'h8000_0008, 1'b0, 3'd0, -1, 1'b0, 0);

        // Nine tags on set 0; the ninth evicts way 5.
        for (int k = 0; k < 8; k++) begin
            fetch(32'h1000_0000 + 32'(k * 128), 1'b0, 3'(k), -1, 1'b0, 0);
        end
        fetch(32'h1000_0400, 1'b0, 3'd5, -1, 1'b0, 0);
        fetch(32'h1000_0404, 1'b1, 3'd5, -1, 1'b0, 0);
        fetch(32'h1000_0280, 1'b0, 3'd6, -1, 1'b0, 0);
        fetch(32'h1000_0200, 1'b1, 3'd4, -1, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
